// File: rtl/gat_pkg.sv
// Shared types and constants for the GAT BRAM ingress controller.
package gat_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } gat_state_e;

    localparam int STAT_STATE_LSB = 0;
    localparam int STAT_DONE_LSB  = 2;
    localparam int STAT_MISALIGN  = 16;
    localparam int STAT_RANGE     = 17;
    localparam int STAT_LATE      = 18;

    localparam int CH_H_DATA      = 0;
    localparam int CH_NODE_INFO   = 1;
    localparam int CH_WGT         = 2;
    localparam int GAT_NUM_CH_DEF = CH_WGT + 1;

endpackage

// File: rtl/gat_ingress_ch.sv
// One PS-to-core BRAM write channel: byte-to-word address conversion, range check,
// registered write forwarding, accepted-write counter and done detection.
module gat_ingress_ch
    import gat_pkg::*;
#(
    parameter int WORD_ADDR_W = 18,
    parameter int CNT_W       = 18,
    parameter int DIN_W       = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clr_i,
    input  logic                   load_i,
    input  logic [CNT_W-1:0]       cfg_len_i,
    input  logic                   sw_done_i,
    input  logic [DIN_W-1:0]       s_din_i,
    input  logic                   s_ena_i,
    input  logic                   s_wea_i,
    input  logic [WORD_ADDR_W+1:0] s_addr_i,
    output logic [DIN_W-1:0]       m_din_o,
    output logic                   m_we_o,
    output logic [WORD_ADDR_W-1:0] m_addr_o,
    output logic                   done_o,
    output logic                   err_mis_o,
    output logic                   err_range_o,
    output logic                   err_late_o
);
    localparam int CMP_W = (WORD_ADDR_W > CNT_W) ? WORD_ADDR_W : CNT_W;

    logic [CNT_W-1:0]       len_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   armed_q;
    logic                   m_we_q;
    logic [WORD_ADDR_W-1:0] m_addr_q;
    logic [DIN_W-1:0]       m_din_q;

    logic [CMP_W-1:0] waddr_x;
    logic [CMP_W-1:0] len_x;
    logic             wr;
    logic             aligned;
    logic             in_range;
    logic             accept;

    always_comb begin
        waddr_x = '0;
        waddr_x[WORD_ADDR_W-1:0] = s_addr_i[WORD_ADDR_W+1:2];
        len_x = '0;
        len_x[CNT_W-1:0] = len_q;
        wr          = s_ena_i & s_wea_i;
        aligned     = (s_addr_i[1:0] == 2'b00);
        in_range    = (waddr_x < len_x);
        accept      = wr & load_i & aligned & in_range;
        err_mis_o   = wr & load_i & ~aligned;
        err_range_o = wr & load_i & aligned & ~in_range;
        err_late_o  = wr & ~load_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            len_q    <= '0;
            cnt_q    <= '0;
            armed_q  <= 1'b0;
            m_we_q   <= 1'b0;
            m_addr_q <= '0;
            m_din_q  <= '0;
        end else begin
            m_we_q <= accept;
            if (accept) begin
                m_addr_q <= s_addr_i[WORD_ADDR_W+1:2];
                m_din_q  <= s_din_i;
            end
            if (clr_i) begin
                len_q   <= cfg_len_i;
                cnt_q   <= '0;
                armed_q <= 1'b1;
            end else if (accept && (cnt_q != len_q)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // armed_q keeps status done bits at zero until the first layer is started
    assign done_o   = armed_q & ((cnt_q == len_q) | sw_done_i);
    assign m_we_o   = m_we_q;
    assign m_addr_o = m_addr_q;
    assign m_din_o  = m_din_q;

endmodule

// File: rtl/gat_bram_ingress_ctrl.sv
// GAT layer ingress controller: admits PS BRAM writes during LOAD, then starts the core.
// Phase cycle counters exist only when GAT_INGRESS_PERF_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; PS writes flagged as late
// LOAD  | forwarding PS writes until every channel is done
// RUN   | core running, waiting for core_done rising edge
// DONE  | one cycle, gat_ready set, back to IDLE
module gat_bram_ingress_ctrl
    import gat_pkg::*;
#(
    parameter int NUM_CH      = GAT_NUM_CH_DEF,
    parameter int WORD_ADDR_W = 18,
    parameter int CNT_W       = 18,
    parameter int DIN_W       = 32
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            start_i,
    input  logic                            layer_i,
    input  logic [NUM_CH*CNT_W-1:0]         cfg_len_i,
    input  logic [NUM_CH-1:0]               sw_done_i,
    input  logic [NUM_CH*DIN_W-1:0]         s_din_i,
    input  logic [NUM_CH-1:0]               s_ena_i,
    input  logic [NUM_CH-1:0]               s_wea_i,
    input  logic [NUM_CH*(WORD_ADDR_W+2)-1:0] s_addr_i,
    output logic [NUM_CH*DIN_W-1:0]         m_din_o,
    output logic [NUM_CH-1:0]               m_we_o,
    output logic [NUM_CH*WORD_ADDR_W-1:0]   m_addr_o,
    output logic                            core_start_o,
    output logic                            core_layer_o,
    input  logic                            core_done_i,
    output logic                            gat_ready_o,
    input  logic                            ready_clr_i,
    output logic [31:0]                     status_o,
    output logic [31:0]                     perf_load_o,
    output logic [31:0]                     perf_run_o
);
    gat_state_e state_q;
    logic       core_done_q;
    logic       core_start_q;
    logic       core_layer_q;
    logic       gat_ready_q;
    logic [2:0] err_q;

    logic              start_acc;
    logic              in_load;
    logic              all_done;
    logic [NUM_CH-1:0] ch_done;
    logic [NUM_CH-1:0] ch_mis;
    logic [NUM_CH-1:0] ch_range;
    logic [NUM_CH-1:0] ch_late;

    assign start_acc = start_i & (state_q == ST_IDLE);
    assign in_load   = (state_q == ST_LOAD);
    assign all_done  = &ch_done;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        gat_ingress_ch #(
            .WORD_ADDR_W (WORD_ADDR_W),
            .CNT_W       (CNT_W),
            .DIN_W       (DIN_W)
        ) u_ch (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .clr_i       (start_acc),
            .load_i      (in_load),
            .cfg_len_i   (cfg_len_i[g*CNT_W +: CNT_W]),
            .sw_done_i   (sw_done_i[g]),
            .s_din_i     (s_din_i[g*DIN_W +: DIN_W]),
            .s_ena_i     (s_ena_i[g]),
            .s_wea_i     (s_wea_i[g]),
            .s_addr_i    (s_addr_i[g*(WORD_ADDR_W+2) +: (WORD_ADDR_W+2)]),
            .m_din_o     (m_din_o[g*DIN_W +: DIN_W]),
            .m_we_o      (m_we_o[g]),
            .m_addr_o    (m_addr_o[g*WORD_ADDR_W +: WORD_ADDR_W]),
            .done_o      (ch_done[g]),
            .err_mis_o   (ch_mis[g]),
            .err_range_o (ch_range[g]),
            .err_late_o  (ch_late[g])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            core_done_q  <= 1'b0;
            core_start_q <= 1'b0;
            core_layer_q <= 1'b0;
            gat_ready_q  <= 1'b0;
            err_q        <= '0;
        end else begin
            core_done_q  <= core_done_i;
            core_start_q <= 1'b0;
            // a set in the same cycle below overrides this clear
            if (ready_clr_i) gat_ready_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (start_i) begin
                    state_q      <= ST_LOAD;
                    core_layer_q <= layer_i;
                end
                ST_LOAD: if (all_done) begin
                    state_q      <= ST_RUN;
                    core_start_q <= 1'b1;
                end
                ST_RUN: if (core_done_i && !core_done_q) begin
                    state_q     <= ST_DONE;
                    gat_ready_q <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
            err_q <= (start_acc ? 3'b000 : err_q) | {(|ch_late), (|ch_range), (|ch_mis)};
        end
    end

    always_comb begin
        status_o = '0;
        status_o[STAT_STATE_LSB +: 2]      = state_q;
        status_o[STAT_DONE_LSB +: NUM_CH]  = ch_done;
        status_o[STAT_MISALIGN]            = err_q[0];
        status_o[STAT_RANGE]               = err_q[1];
        status_o[STAT_LATE]                = err_q[2];
    end

    assign core_start_o = core_start_q;
    assign core_layer_o = core_layer_q;
    assign gat_ready_o  = gat_ready_q;

`ifdef GAT_INGRESS_PERF_EN
    logic [31:0] perf_load_q;
    logic [31:0] perf_run_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || start_acc) begin
            perf_load_q <= '0;
            perf_run_q  <= '0;
        end else begin
            if (state_q == ST_LOAD && perf_load_q != 32'hFFFF_FFFF) perf_load_q <= perf_load_q + 1'b1;
            if (state_q == ST_RUN  && perf_run_q  != 32'hFFFF_FFFF) perf_run_q  <= perf_run_q + 1'b1;
        end
    end

    assign perf_load_o = perf_load_q;
    assign perf_run_o  = perf_run_q;
`else
    assign perf_load_o = '0;
    assign perf_run_o  = '0;
`endif

endmodule

// File: tb/tb_gat_bram_ingress_ctrl.sv
// Scoreboard bench for gat_bram_ingress_ctrl: expected core writes are queued at issue
// and popped by a negedge monitor; control/status checked with directed sequences.
module tb_gat_bram_ingress_ctrl;
    localparam int NCH = 3;
    localparam int WA  = 18;
    localparam int CW  = 18;
    localparam int DW  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              layer;
    logic [NCH*CW-1:0] cfg_len;
    logic [NCH-1:0]    sw_done;
    logic [NCH*DW-1:0] s_din;
    logic [NCH-1:0]    s_ena;
    logic [NCH-1:0]    s_wea;
    logic [NCH*(WA+2)-1:0] s_addr;
    logic [NCH*DW-1:0] m_din;
    logic [NCH-1:0]    m_we;
    logic [NCH*WA-1:0] m_addr;
    logic              core_start;
    logic              core_layer;
    logic              core_done;
    logic              gat_ready;
    logic              ready_clr;
    logic [31:0]       status;
    logic [31:0]       perf_load;
    logic [31:0]       perf_run;

    gat_bram_ingress_ctrl #(
        .NUM_CH(NCH), .WORD_ADDR_W(WA), .CNT_W(CW), .DIN_W(DW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .layer_i      (layer),
        .cfg_len_i    (cfg_len),
        .sw_done_i    (sw_done),
        .s_din_i      (s_din),
        .s_ena_i      (s_ena),
        .s_wea_i      (s_wea),
        .s_addr_i     (s_addr),
        .m_din_o      (m_din),
        .m_we_o       (m_we),
        .m_addr_o     (m_addr),
        .core_start_o (core_start),
        .core_layer_o (core_layer),
        .core_done_i  (core_done),
        .gat_ready_o  (gat_ready),
        .ready_clr_i  (ready_clr),
        .status_o     (status),
        .perf_load_o  (perf_load),
        .perf_run_o   (perf_run)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        logic [17:0] addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   cs_count = 0;
    int   cs_cyc = 0;
    int   last_we_cyc;
    logic [31:0] exp_perf_load;
    logic [31:0] exp_perf_run;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every core-side write must match the oldest queued expectation.
    always @(negedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (m_we[c]) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_m_we", 64'(c), 64'hFFFF);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("wr_channel", 64'(c), 64'(e.ch));
                    check("wr_m_addr", 64'(m_addr[c*WA +: WA]), 64'(e.addr));
                    check("wr_m_din", 64'(m_din[c*DW +: DW]), 64'(e.data));
                    check("wr_latency_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
        if (core_start) begin
            cs_count++;
            cs_cyc = cyc;
        end
    end

    task automatic wr(input int ch, input logic [19:0] addr, input logic [31:0] data, input bit exp_acc);
        exp_t e;
        s_ena[ch] = 1'b1;
        s_wea[ch] = 1'b1;
        s_addr[ch*(WA+2) +: (WA+2)] = addr;
        s_din[ch*DW +: DW] = data;
        if (exp_acc) begin
            e.ch = ch; e.addr = addr[19:2]; e.data = data; e.cyc = cyc + 1;
            sb_q.push_back(e);
        end
        @(negedge clk);
        s_ena[ch] = 1'b0;
        s_wea[ch] = 1'b0;
    endtask

    task automatic do_start(input logic [NCH*CW-1:0] len, input logic lay);
        cfg_len = len;
        layer = lay;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
`ifdef GAT_INGRESS_PERF_EN
        exp_perf_load = 32'd10;
        exp_perf_run  = 32'd25;
`else
        exp_perf_load = 32'd0;
        exp_perf_run  = 32'd0;
`endif
        rst = 1'b1; start = 1'b0; layer = 1'b0; cfg_len = '0; sw_done = '0;
        s_din = '0; s_ena = '0; s_wea = '0; s_addr = '0;
        core_done = 1'b0; ready_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_status", 64'(status), 64'h0);
        check("reset_m_we", 64'(m_we), 64'h0);
        check("reset_gat_ready", 64'(gat_ready), 64'h0);
        check("reset_core_start", 64'(core_start), 64'h0);

        // Layer 1: lengths 4/2/3, all aligned in-range writes
        do_start({18'd3, 18'd2, 18'd4}, 1'b0);
        check("t1_state_load", 64'(status[1:0]), 64'd1);
        for (int i = 0; i < 4; i++) wr(0, 20'(i * 4), 32'hA000_0000 + 32'(i), 1'b1);
        for (int i = 0; i < 2; i++) wr(1, 20'(i * 4), 32'hB000_0000 + 32'(i), 1'b1);
        check("t1_not_started_early", 64'(cs_count), 64'd0);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) last_we_cyc = cyc + 1;
            wr(2, 20'(i * 4), 32'hC000_0000 + 32'(i), 1'b1);
        end
        repeat (2) @(negedge clk);
        check("t1_core_start_pulses", 64'(cs_count), 64'd1);
        check("t1_core_start_cycle", 64'(cs_cyc), 64'(last_we_cyc + 1));
        check("t1_state_run", 64'(status[1:0]), 64'd2);
        check("t1_ch_done", 64'(status[4:2]), 64'h7);
        check("t1_no_errors", 64'(status[18:16]), 64'h0);
        core_done = 1'b1;
        @(negedge clk);
        check("t1_state_done", 64'(status[1:0]), 64'd3);
        check("t1_gat_ready_set", 64'(gat_ready), 64'd1);
        @(negedge clk);
        check("t1_state_idle", 64'(status[1:0]), 64'd0);
        check("t1_gat_ready_held", 64'(gat_ready), 64'd1);
        core_done = 1'b0;
        ready_clr = 1'b1;
        @(negedge clk);
        ready_clr = 1'b0;
        check("t1_gat_ready_cleared", 64'(gat_ready), 64'd0);

        // Layer 2: misaligned / out-of-range drops, duplicate counted, zero-length channels
        do_start({18'd0, 18'd0, 18'd4}, 1'b0);
        wr(0, 20'h6, 32'hDEAD_0006, 1'b0);
        check("t2_misalign_flag", 64'(status[17:16]), 64'b01);
        wr(0, 20'h0, 32'h1111_0000, 1'b1);
        wr(0, 20'h4, 32'h1111_0001, 1'b1);
        wr(0, 20'h8, 32'h1111_0002, 1'b1);
        check("t2_ch0_not_done_3of4", 64'(status[2]), 64'd0);
        wr(0, 20'h10, 32'hDEAD_0010, 1'b0);
        check("t2_range_flag", 64'(status[17]), 64'd1);
        check("t2_ch0_not_done_after_drop", 64'(status[2]), 64'd0);
        wr(0, 20'h0, 32'h2222_0000, 1'b1);
        check("t2_all_done_dup", 64'(status[4:2]), 64'h7);
        @(negedge clk);
        check("t2_state_run", 64'(status[1:0]), 64'd2);
        check("t2_errors_sticky", 64'(status[18:16]), 64'b011);
        core_done = 1'b1;
        ready_clr = 1'b1;
        @(negedge clk);
        check("t2_set_beats_clear", 64'(gat_ready), 64'd1);
        @(negedge clk);
        check("t2_clear_next", 64'(gat_ready), 64'd0);
        ready_clr = 1'b0;
        core_done = 1'b0;
        check("t2_errors_sticky_idle", 64'(status[18:16]), 64'b011);

        // Layer 3: software done with no writes; phase timing 10 LOAD / 25 RUN
        do_start({18'd4, 18'd4, 18'd4}, 1'b1);
        check("t3_errors_cleared", 64'(status[18:16]), 64'h0);
        check("t3_core_layer", 64'(core_layer), 64'd1);
        check("t3_no_done_yet", 64'(status[4:2]), 64'h0);
        repeat (9) @(negedge clk);
        check("t3_still_load", 64'(status[1:0]), 64'd1);
        sw_done = 3'b111;
        @(negedge clk);
        check("t3_core_start_high", 64'(core_start), 64'd1);
        check("t3_state_run", 64'(status[1:0]), 64'd2);
        @(negedge clk);
        check("t3_core_start_pulse", 64'(core_start), 64'd0);
        sw_done = 3'b000;
        repeat (23) @(negedge clk);
        check("t3_no_ready_before_done", 64'(gat_ready), 64'd0);
        core_done = 1'b1;
        @(negedge clk);
        check("t3_gat_ready", 64'(gat_ready), 64'd1);
        @(negedge clk);
        core_done = 1'b0;
        check("t3_perf_load", 64'(perf_load), 64'(exp_perf_load));
        check("t3_perf_run", 64'(perf_run), 64'(exp_perf_run));
        check("t3_core_start_total", 64'(cs_count), 64'd3);
        repeat (3) @(negedge clk);
        check("t3_gat_ready_holds", 64'(gat_ready), 64'd1);

        // Layer 4: reset mid-LOAD with a write in flight, then late write in IDLE
        do_start({18'd3, 18'd2, 18'd4}, 1'b1);
        wr(0, 20'h0, 32'h3333_0000, 1'b1);
        wr(0, 20'h4, 32'h3333_0001, 1'b1);
        s_ena[0] = 1'b1; s_wea[0] = 1'b1;
        s_addr[0 +: WA+2] = 20'h8; s_din[0 +: DW] = 32'h3333_0002;
        rst = 1'b1;
        @(negedge clk);
        s_ena[0] = 1'b0; s_wea[0] = 1'b0;
        rst = 1'b0;
        check("t4_rst_status", 64'(status), 64'h0);
        check("t4_rst_m_we", 64'(m_we), 64'h0);
        check("t4_rst_m_addr", 64'(m_addr), 64'h0);
        check("t4_rst_m_din", 64'(m_din[63:0]), 64'h0);
        check("t4_rst_core_layer", 64'(core_layer), 64'd0);
        check("t4_rst_gat_ready", 64'(gat_ready), 64'd0);
        check("t4_rst_core_start", 64'(core_start), 64'd0);
        check("t4_rst_perf", 64'({perf_load, perf_run}), 64'h0);
        wr(1, 20'h0, 32'h4444_0000, 1'b0);
        check("t4_late_flag", 64'(status[18]), 64'd1);
        check("t4_late_m_we", 64'(m_we), 64'h0);
        check("t4_late_state_idle", 64'(status[1:0]), 64'd0);
        repeat (2) @(negedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gat_bram_ingress_ctrl.md
GAT_BRAM_INGRESS_CTRL -- requirements
Module: gat_bram_ingress_ctrl

Interface
REQ-001 Parameter NUM_CH, default 3; number of PS-to-core BRAM write channels (0=h_data, 1=node_info, 2=wgt).
REQ-002 Parameter WORD_ADDR_W, default 18; core-side word address width.
REQ-003 Parameter CNT_W, default 18; per-channel write-count width.
REQ-004 Parameter DIN_W, default 32; PS write data width.
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle pulse; begins load for one GAT layer.
REQ-008 layer  in  1  layer select; sampled on accepted start.
REQ-009 cfg_len  in  NUM_CH*CNT_W  expected word count per channel; sampled on accepted start.
REQ-010 sw_done  in  NUM_CH  software load-done per channel (level).
REQ-011 s_din / s_ena / s_wea / s_addr  in  NUM_CH*DIN_W / NUM_CH / NUM_CH / NUM_CH*(WORD_ADDR_W+2)  PS BRAM write ports; s_addr is byte address.
REQ-012 m_din / m_we / m_addr  out  NUM_CH*DIN_W / NUM_CH / NUM_CH*WORD_ADDR_W  core BRAM write ports, word address.
REQ-013 core_start  out  1  one-cycle start pulse to gat_top; core_layer  out  1  latched layer.
REQ-014 core_done  in  1  core completion (level, edge-detected here).
REQ-015 gat_ready  out  1  sticky layer-complete flag; ready_clr  in  1  clears it.
REQ-016 status  out  32  [1:0] state, [2+NUM_CH-1:2] channel done, [16] misalign err, [17] range err, [18] late-write err.
REQ-017 perf_load / perf_run  out  32 each  phase cycle counters.

Function
REQ-018 FSM states IDLE, LOAD, RUN, DONE; encoded 0..3 on status[1:0].
REQ-019 IDLE: start -> LOAD, clear per-channel counts/done, latch layer and cfg_len; start in any other state ignored.
REQ-020 Write accepted when state==LOAD, s_ena&s_wea, s_addr[1:0]==0, word address < latched cfg_len.
REQ-021 Accepted write -> next cycle m_we=1, m_addr=s_addr[WORD_ADDR_W+1:2], m_din=s_din (latency exactly 1); otherwise m_we=0.
REQ-022 Misaligned write dropped, sets status[16]; out-of-range word address dropped, sets status[17].
REQ-023 Write while not LOAD dropped; sets status[18].
REQ-024 Count increments per accepted write (duplicates counted), saturates at cfg_len; channel done when count==cfg_len or sw_done high; cfg_len==0 -> done immediately.
REQ-025 All channels done in LOAD -> core_start pulse the cycle after last done write's m_we, state -> RUN.
REQ-026 RUN: core_done rising edge -> DONE, gat_ready=1; DONE -> IDLE next cycle; gat_ready holds until ready_clr.
REQ-027 ready_clr and set same cycle -> set wins.
REQ-028 Error bits sticky; cleared only by rst or accepted start.

Reset
REQ-029 rst in any state -> IDLE next edge; m_we=0, m_addr=0, m_din=0, core_start=0, core_layer=0, gat_ready=0, status=0, counts=0, perf counters=0; in-flight write discarded.

Configuration
REQ-030 Macro GAT_INGRESS_PERF_EN defined: perf_load counts cycles in LOAD, perf_run counts cycles in RUN, both saturate at 2^32-1, cleared on accepted start.
REQ-031 Macro undefined: perf_load=perf_run=0 constant, no counter logic.

Structure
REQ-032 Package gat_pkg holds state enum, status bit-position constants, default channel indices.
REQ-033 One sub-module gat_ingress_ch (per-channel address convert, range check, counter, done), instantiated NUM_CH times via generate.

Verification
REQ-034 start, cfg_len={4,2,3}; 4/2/3 aligned writes -> m_addr=0..n-1 one cycle later, core_start one pulse, status[1:0]=2.
REQ-035 Write s_addr=0x6 in LOAD -> m_we stays 0, status[16]=1, count unchanged.
REQ-036 cfg_len[ch0]=4, write s_addr=0x10 -> dropped, status[17]=1.
REQ-037 sw_done=3'b111 with zero writes -> core_start next cycle; core_done 0->1 -> gat_ready=1 until ready_clr.
REQ-038 rst asserted mid-LOAD after 2 writes -> IDLE, all outputs 0; write during IDLE -> status[18]=1, m_we=0.
REQ-039 With GAT_INGRESS_PERF_EN: 10 cycles LOAD, 25 cycles RUN -> perf_load=10, perf_run=25; without: both 0.
